// File: rtl/veridog_pkg.sv
// Shared types and event encodings for the dog game controller.
package veridog_pkg;

   localparam int EVT_W = 2;

   localparam logic [EVT_W-1:0] EVT_BARK  = 2'd0;
   localparam logic [EVT_W-1:0] EVT_SIT   = 2'd1;
   localparam logic [EVT_W-1:0] EVT_FETCH = 2'd2;
   localparam logic [EVT_W-1:0] EVT_SLEEP = 2'd3;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CHECK = 2'd1,
      HOLD  = 2'd2
   } pick_state_t;

   function automatic logic [(1 << EVT_W)-1:0] evt_onehot(input logic [EVT_W-1:0] idx);
      return {{((1 << EVT_W)-1){1'b0}}, 1'b1} << idx;
   endfunction

endpackage

// File: rtl/hold_timer.sv
// Loadable down-counter; done flags the last cycle of the loaded interval.
module hold_timer #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         done
);

   logic [W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (cnt != '0) begin
         cnt <= cnt - W'(1);
      end
   end

   assign done = (cnt == W'(1));

endmodule

// File: rtl/rand_event_picker.sv
// Samples the free-running random counter on request and commits one of four
// dog events, rerolling a bounded number of times to avoid immediate repeats.
//
//   state | meaning
//   IDLE  | waiting for req; busy low
//   CHECK | candidate held; reroll if it repeats the last event, else commit
//   HOLD  | cooldown after a commit; req ignored
module rand_event_picker
   import veridog_pkg::*;
#(
   parameter int HOLD_CYCLES = 8,
   parameter int MAX_REROLL  = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [EVT_W-1:0] rand_in,
   input  logic             req,
   output logic             ack,
   output logic [EVT_W-1:0] event_idx,
   output logic [3:0]       event_onehot,
   output logic             busy
);

   localparam int RW = (MAX_REROLL  > 0) ? $clog2(MAX_REROLL + 1)  : 1;
   localparam int HW = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;
   localparam logic [RW-1:0] MAX_RR   = RW'(MAX_REROLL);
   localparam logic [HW-1:0] HOLD_VAL = HW'(HOLD_CYCLES);

   pick_state_t      state;
   logic [EVT_W-1:0] cand;
   logic [EVT_W-1:0] last_idx;
   logic             has_last;
   logic [RW-1:0]    reroll_cnt;
   logic             repeat_hit;
   logic             commit;
   logic             hold_load;
   logic             hold_done;

   // reroll_cnt never exceeds MAX_RR, so != doubles as the "< MAX_REROLL" test
   always_comb begin
      repeat_hit = has_last && (cand == last_idx) && (reroll_cnt != MAX_RR);
      commit     = (state == CHECK) && !repeat_hit;
      hold_load  = commit && (HOLD_CYCLES > 0);
   end

   hold_timer #(.W(HW)) u_hold_timer (
      .clk      (clk),
      .reset    (reset),
      .load     (hold_load),
      .load_val (HOLD_VAL),
      .done     (hold_done)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= IDLE;
         ack          <= 1'b0;
         event_idx    <= '0;
         event_onehot <= '0;
         busy         <= 1'b0;
         cand         <= '0;
         last_idx     <= '0;
         has_last     <= 1'b0;
         reroll_cnt   <= '0;
      end else begin
         ack <= 1'b0;
         case (state)
            IDLE: begin
               if (req) begin
                  cand       <= rand_in;
                  reroll_cnt <= '0;
                  state      <= CHECK;
                  busy       <= 1'b1;
               end
            end
            CHECK: begin
               if (repeat_hit) begin
                  cand       <= rand_in;
                  reroll_cnt <= reroll_cnt + RW'(1);
               end else begin
                  event_idx    <= cand;
                  event_onehot <= evt_onehot(cand);
                  last_idx     <= cand;
                  has_last     <= 1'b1;
                  ack          <= 1'b1;
                  if (HOLD_CYCLES > 0) begin
                     state <= HOLD;
                  end else begin
                     state <= IDLE;
                     busy  <= 1'b0;
                  end
               end
            end
            HOLD: begin
               if (hold_done) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/rand_event_picker.md
Name: rand_event_picker

Overview:
- Consumer end of the 2-bit free-running pseudo-random counter.
- On a request from the dog game FSM, it samples `rand_in` and commits one of four dog events, with one-hot and index outputs.
- It avoids repeating the previous event, using bounded rerolls, then holds off further picks for a cooldown period.
- Sits between the random counter and the top-level game controller.

Parameters:
- HOLD_CYCLES, 8: cooldown cycles spent in HOLD after each commit. 0 means return to IDLE immediately.
- MAX_REROLL, 3: maximum resamples when the candidate equals the last committed event. 0 means no repeat avoidance.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- rand_in  in  2  current value of the pseudo-random counter.
- req  in  1  pick request; level-sensitive, sampled only in IDLE.
- ack  out  1  one-cycle pulse: new event committed.
- event_idx  out  2  last committed event index; held until the next commit.
- event_onehot  out  4  equals 1 << event_idx after a commit; 0 before the first commit.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (reset=1 at an edge):
  - state=IDLE; ack=0; event_idx=0; event_onehot=0; busy=0.
  - Internal state cleared: has_last=0, last_idx=0, reroll_cnt=0, hold_cnt=0.
  - Reset overrides all other activity: a pick in progress is aborted and no ack is issued.
- FSM states: IDLE, CHECK, HOLD.
- IDLE, with req=1 at edge N: cand<=rand_in, reroll_cnt<=0, state<=CHECK.
- CHECK, at each edge:
  - Repeat case (has_last=1, cand==last_idx and reroll_cnt<MAX_REROLL): cand<=rand_in, reroll_cnt<=reroll_cnt+1, stay in CHECK.
  - Otherwise commit:
    - event_idx<=cand, event_onehot<=1<<cand, last_idx<=cand, has_last<=1, ack<=1.
    - If HOLD_CYCLES>0: state<=HOLD, hold_cnt<=HOLD_CYCLES. If HOLD_CYCLES=0: state<=IDLE.
- Latency:
  - With no reroll, the commit edge is N+1.
  - Each reroll adds one cycle.
  - Worst case, the commit edge is N+1+MAX_REROLL, then committed unconditionally, even if the value repeats.
- ack: high for exactly the one cycle following the commit edge, then 0.
- HOLD:
  - hold_cnt decrements each edge.
  - When hold_cnt==1, state<=IDLE, so HOLD lasts exactly HOLD_CYCLES cycles.
  - busy therefore falls at edge N+1+R+HOLD_CYCLES, where R is the reroll count.
- req handling:
  - req outside IDLE is ignored, not queued.
  - req held high is re-sampled on the first IDLE cycle, which starts the next pick back-to-back.
- Widths:
  - reroll_cnt: $clog2(MAX_REROLL+1), minimum 1 bit.
  - hold_cnt: $clog2(HOLD_CYCLES+1), minimum 1 bit.
  - No wrap is possible; counters are bounded by their parameters.
- rand_in is treated as already synchronous to clk; there is no extra synchroniser.

Decomposition:
- Shared package veridog_pkg holds:
  - State enum: IDLE, CHECK, HOLD.
  - Event constants: EVT_BARK=0, EVT_SIT=1, EVT_FETCH=2, EVT_SLEEP=3.
  - EVT_W=2.
- Sub-module hold_timer: loadable down-counter.
  - Ports: clk, reset, load, load_val, done.
  - Parameterised width; instantiated once for the HOLD cooldown.
- FSM and reroll logic stay in rand_event_picker.

Test Plan:
- Reset: hold reset=1 for 2 cycles with req=1 and rand_in=3 -> ack=0, busy=0, event_idx=0, event_onehot=0000 throughout; no pick starts.
- First pick (HOLD_CYCLES=8): rand_in=2, req pulse at edge N -> at edge N+1 event_idx=2, event_onehot=0100, ack=1 for one cycle; busy=1 from N through N+8, busy=0 after edge N+9.
- Repeat avoidance: last_idx=2, req at N, rand_in=2 at N, 2 at N+1, 3 at N+2 -> two rerolls; commit at edge N+3 with event_idx=3, onehot=1000; single ack pulse.
- Forced commit: last_idx=2, rand_in stuck at 2, MAX_REROLL=3 -> commit at edge N+4, event_idx=2, ack=1 once.
- Ignore/back-to-back: extra req pulses during HOLD -> no extra ack. req held high continuously -> next pick samples on the first IDLE cycle; exactly one ack per pick.
- Reset mid-op:
  - reset during CHECK (rerolling) -> no ack, outputs return to 0.
  - reset during HOLD -> busy=0 next cycle.
  - Subsequent pick with rand_in=2 commits at N+1 with no reroll, since has_last was cleared.
